// File: rtl/aes_spi_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : aes_spi_scheduler
//  Purpose  : Round-robin SPI master shared by the encrypt/decrypt requesters;
//             sends {data, key}, idles LAT SCLK periods, reads back 128 bits.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_spi_scheduler #(
    parameter int Nk  = 4,
    parameter int DIV = 1,
    parameter int LAT = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_enc,
    input  logic              req_dec,
    input  logic [127:0]      data_enc,
    input  logic [127:0]      data_dec,
    input  logic [Nk*32-1:0]  key_enc,
    input  logic [Nk*32-1:0]  key_dec,
    output logic              ack_enc,
    output logic              ack_dec,
    output logic              done_enc,
    output logic              done_dec,
    output logic [127:0]      result,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_enc_n,
    output logic              cs_dec_n
);

    localparam int N_TX  = 128 + 32 * Nk;
    localparam int CNT_W = $clog2(N_TX + 1);
    localparam int PH_W  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_send = 2'd1;
    localparam logic [1:0] c_wait = 2'd2;
    localparam logic [1:0] c_recv = 2'd3;

    localparam logic [PH_W-1:0]  c_ph_last   = PH_W'(DIV - 1);
    localparam logic [CNT_W-1:0] c_send_last = CNT_W'(N_TX - 1);
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'((LAT > 0) ? LAT - 1 : 0);
    localparam logic [CNT_W-1:0] c_recv_last = CNT_W'(127);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [PH_W-1:0]  r_phase;
    logic             r_sclk;
    logic [CNT_W-1:0] r_cnt;
    logic [N_TX-1:0]  r_tx;
    logic [127:0]     r_rx;
    logic [127:0]     r_result;
    logic             r_owner;      // 1 = decrypt requester
    logic             r_last;       // 1 = decrypt was granted last
    logic             r_done_enc;
    logic             r_done_dec;

    logic w_ph_end;
    logic w_rise;
    logic w_fall;
    logic w_cnt_end;
    logic w_step_done;
    logic w_grant_ok;
    logic w_pick_enc;
    logic w_grant_enc;
    logic w_grant_dec;
    logic w_busy;

    assign w_ph_end    = (r_phase == c_ph_last);
    assign w_rise      = ~r_sclk & w_ph_end;
    assign w_fall      = r_sclk & w_ph_end;
    assign w_step_done = w_fall & w_cnt_end;
    assign w_busy      = (r_state != c_idle);

    // No grant in the done cycle, so ack and done never coincide.
    assign w_grant_ok  = (r_state == c_idle) & ~r_done_enc & ~r_done_dec;
    assign w_pick_enc  = req_enc & (~req_dec | r_last);
    assign w_grant_enc = w_grant_ok & w_pick_enc;
    assign w_grant_dec = w_grant_ok & req_dec & ~w_pick_enc;

    always_comb begin
        w_cnt_end = 1'b0;
        case (r_state)
            c_send:  w_cnt_end = (r_cnt == c_send_last);
            c_wait:  w_cnt_end = (r_cnt == c_wait_last);
            c_recv:  w_cnt_end = (r_cnt == c_recv_last);
            default: w_cnt_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_grant_enc | w_grant_dec) w_next_state = c_send;
            c_send:  if (w_step_done) w_next_state = (LAT == 0) ? c_recv : c_wait;
            c_wait:  if (w_step_done) w_next_state = c_recv;
            c_recv:  if (w_step_done) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        ack_enc  = w_grant_enc;
        ack_dec  = w_grant_dec;
        busy     = w_busy;
        mosi     = (r_state == c_send) ? r_tx[N_TX-1] : 1'b0;
        cs_enc_n = ~(w_busy & ~r_owner);
        cs_dec_n = ~(w_busy & r_owner);
    end

    // Bit counter and shift registers advance on the SCLK falling edge;
    // MISO is taken on the rising edge, matching the slaves' sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase    <= '0;
            r_sclk     <= 1'b0;
            r_cnt      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_result   <= '0;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_done_enc <= 1'b0;
            r_done_dec <= 1'b0;
        end else begin
            r_done_enc <= 1'b0;
            r_done_dec <= 1'b0;
            if (w_grant_enc | w_grant_dec) begin
                r_tx    <= w_grant_dec ? {data_dec, key_dec} : {data_enc, key_enc};
                r_owner <= w_grant_dec;
                r_last  <= w_grant_dec;
                r_phase <= '0;
                r_sclk  <= 1'b0;
                r_cnt   <= '0;
            end else if (w_busy) begin
                if (w_ph_end) begin
                    r_phase <= '0;
                    r_sclk  <= ~r_sclk;
                end else begin
                    r_phase <= r_phase + 1'b1;
                end
                if (w_rise && (r_state == c_recv)) begin
                    r_rx <= {r_rx[126:0], miso};
                end
                if (w_fall) begin
                    r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
                    if (r_state == c_send) begin
                        r_tx <= {r_tx[N_TX-2:0], 1'b0};
                    end
                    if ((r_state == c_recv) && w_cnt_end) begin
                        r_result   <= r_rx;
                        r_done_enc <= ~r_owner;
                        r_done_dec <= r_owner;
                    end
                end
            end
        end
    end

    assign done_enc = r_done_enc;
    assign done_dec = r_done_dec;
    assign result   = r_result;
    assign sclk     = r_sclk;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_spi_scheduler
//  Purpose  : Bench for aes_spi_scheduler: transaction-level reference model
//             checked every cycle, plus a DIV=3/Nk=8/LAT=14 variant instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_spi_scheduler;

    localparam int NK   = 4;
    localparam int DIVA = 1;
    localparam int LATA = 12;
    localparam int NTX  = 128 + 32 * NK;
    localparam int TLEN = 2 * DIVA * (NTX + LATA + 128);
    localparam int NKB  = 8;
    localparam int DIVB = 3;
    localparam int LATB = 14;
    localparam int NTXB = 128 + 32 * NKB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main instance ----------------
    logic           req_enc = 1'b0, req_dec = 1'b0;
    logic [127:0]   data_enc = '0, data_dec = '0;
    logic [NTX-128-1:0] key_enc = '0, key_dec = '0;
    logic           ack_enc, ack_dec, done_enc, done_dec, busy, sclk, mosi, cs_enc_n, cs_dec_n;
    logic           miso = 1'b0;
    logic [127:0]   result;

    aes_spi_scheduler #(.Nk(NK), .DIV(DIVA), .LAT(LATA)) dut (
        .clk(clk), .rst(rst), .req_enc(req_enc), .req_dec(req_dec),
        .data_enc(data_enc), .data_dec(data_dec), .key_enc(key_enc), .key_dec(key_dec),
        .ack_enc(ack_enc), .ack_dec(ack_dec), .done_enc(done_enc), .done_dec(done_dec),
        .result(result), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso),
        .cs_enc_n(cs_enc_n), .cs_dec_n(cs_dec_n)
    );

    // ---------------- variant instance ----------------
    logic               b_req = 1'b0;
    logic [127:0]       b_data = '0;
    logic [NTXB-128-1:0] b_key = '0;
    logic               b_ack_enc, b_ack_dec, b_done_enc, b_done_dec, b_busy, b_sclk, b_mosi;
    logic               b_cs_enc_n, b_cs_dec_n;
    logic               b_miso = 1'b0;
    logic [127:0]       b_result;

    aes_spi_scheduler #(.Nk(NKB), .DIV(DIVB), .LAT(LATB)) dut_b (
        .clk(clk), .rst(rst), .req_enc(b_req), .req_dec(1'b0),
        .data_enc(b_data), .data_dec(128'd0), .key_enc(b_key), .key_dec({(NTXB-128){1'b0}}),
        .ack_enc(b_ack_enc), .ack_dec(b_ack_dec), .done_enc(b_done_enc), .done_dec(b_done_dec),
        .result(b_result), .busy(b_busy), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso),
        .cs_enc_n(b_cs_enc_n), .cs_dec_n(b_cs_dec_n)
    );

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- slave BFM (main) ----------------
    logic [127:0]   slave_resp = '0;
    logic [NTX-1:0] cap_frame = '0;
    int             s_rises = 0;
    logic           s_prev = 1'b0;

    always @(negedge clk) begin
        if (rst || (cs_enc_n && cs_dec_n)) begin
            s_rises = 0;
            s_prev  = 1'b0;
            miso    = 1'($urandom);
        end else begin
            if (sclk && !s_prev) begin
                if (s_rises < NTX) cap_frame[NTX-1-s_rises] = mosi;
                s_rises++;
            end
            s_prev = sclk;
            if (s_rises >= NTX + LATA && s_rises < NTX + LATA + 128)
                miso = slave_resp[127-(s_rises-NTX-LATA)];
            else
                miso = 1'($urandom);
        end
    end

    // ---------------- event monitor (main) ----------------
    int n_done = 0, n_ack = 0, done_cyc = 0, ack_cyc = 0, csd_first_low = -1;
    bit csd_low_seen = 1'b0;
    int ack_q[$], done_q[$];
    bit who_q[$];

    always @(negedge clk) begin
        if (ack_enc || ack_dec) begin
            n_ack++; ack_cyc = cyc; ack_q.push_back(cyc); who_q.push_back(ack_dec);
        end
        if (done_enc || done_dec) begin
            n_done++; done_cyc = cyc; done_q.push_back(cyc);
        end
        if (!cs_dec_n) begin
            if (!csd_low_seen) csd_first_low = cyc;
            csd_low_seen = 1'b1;
        end
    end

    // ---------------- transaction-level reference model ----------------
    // A transaction is described by its start cycle; every output inside it
    // follows from the elapsed cycle count by plain arithmetic.
    logic           m_busy = 1'b0, m_owner_dec = 1'b0, m_last_dec = 1'b1;
    logic           m_done_flag = 1'b0, m_done_dec = 1'b0;
    int             m_e = 0;
    logic [NTX-1:0] m_frame = '0;
    logic [127:0]   m_resp = '0, m_result = '0;
    logic           fixed_resp_en = 1'b0;
    logic [127:0]   fixed_resp = '0;
    logic           e_ack_enc, e_ack_dec, e_busy, e_sclk, e_mosi, e_cse, e_csd;
    int             m_k, m_per;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_last_dec = 1'b1; m_done_flag = 1'b0; m_result = '0;
        end
        e_ack_enc = 1'b0; e_ack_dec = 1'b0;
        e_busy = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0; e_cse = 1'b1; e_csd = 1'b1;
        if (m_busy) begin
            m_k    = m_e - 1;
            m_per  = m_k / (2 * DIVA);
            e_busy = 1'b1;
            e_sclk = (m_k % (2 * DIVA)) >= DIVA;
            e_mosi = (m_per < NTX) ? m_frame[NTX-1-m_per] : 1'b0;
            e_cse  = m_owner_dec;
            e_csd  = !m_owner_dec;
        end else if (!m_done_flag && !rst && (req_enc || req_dec)) begin
            e_ack_enc = req_enc && (!req_dec || m_last_dec);
            e_ack_dec = !e_ack_enc;
        end
        check("cycle_outputs",
              {ack_enc, ack_dec, done_enc, done_dec, busy, sclk, mosi, cs_enc_n, cs_dec_n, result},
              {e_ack_enc, e_ack_dec, m_done_flag && !m_done_dec, m_done_flag && m_done_dec,
               e_busy, e_sclk, e_mosi, e_cse, e_csd, m_result});
        if (!rst) begin
            m_done_flag = 1'b0;
            if (m_busy) begin
                if (m_e == TLEN) begin
                    m_busy = 1'b0; m_done_flag = 1'b1; m_done_dec = m_owner_dec; m_result = m_resp;
                end else begin
                    m_e++;
                end
            end else if (e_ack_enc || e_ack_dec) begin
                m_busy = 1'b1; m_e = 1; m_owner_dec = e_ack_dec; m_last_dec = e_ack_dec;
                m_frame = e_ack_dec ? {data_dec, key_dec} : {data_enc, key_enc};
                m_resp = fixed_resp_en ? fixed_resp : rnd128();
                slave_resp = m_resp;
            end
        end
    end

    // ---------------- slave BFM + monitor (variant) ----------------
    logic [127:0]    b_resp = '0;
    logic [NTXB-1:0] b_cap = '0;
    int   b_rises = 0, b_rises_at_done = 0, b_n_done = 0, b_done_cyc = 0, b_ack_cyc = 0;
    int   b_run = 0, b_bad = 0, b_trans = 0;
    logic b_prev = 1'b0, b_prev_lvl = 1'b0;

    always @(negedge clk) begin
        if (b_ack_enc) b_ack_cyc = cyc;
        if (b_done_enc) begin
            b_n_done++; b_done_cyc = cyc; b_rises_at_done = b_rises;
        end
        if (rst || b_cs_enc_n) begin
            b_rises = 0; b_prev = 1'b0; b_prev_lvl = 1'b0; b_run = 0;
            b_miso = 1'($urandom);
        end else begin
            if (b_sclk == b_prev_lvl) begin
                b_run++;
            end else begin
                if (b_run != DIVB) b_bad++;
                b_trans++;
                b_run = 1;
            end
            b_prev_lvl = b_sclk;
            if (b_sclk && !b_prev) begin
                if (b_rises < NTXB) b_cap[NTXB-1-b_rises] = b_mosi;
                b_rises++;
            end
            b_prev = b_sclk;
            if (b_rises >= NTXB + LATB && b_rises < NTXB + LATB + 128)
                b_miso = b_resp[127-(b_rises-NTXB-LATB)];
            else
                b_miso = 1'($urandom);
        end
    end

    task automatic wait_done(input int start, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (n_done != start) break;
        end
        check("done_within_budget", n_done != start, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        check("idle_within_budget", busy, 0);
    endtask

    initial begin
        int t0, d, dn, an, sel, hold;
        logic [127:0] lit_d, lit_r;
        logic [127:0] lit_k;
        lit_d = 128'h00112233445566778899aabbccddeeff;
        lit_k = 128'h000102030405060708090a0b0c0d0e0f;
        lit_r = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {ack_enc, ack_dec, done_enc, done_dec, busy, sclk, mosi, cs_enc_n, cs_dec_n},
              9'b0000_000_11);
        check("reset_result", result, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single encrypt with known vectors; operands change right after ack
        fixed_resp_en = 1'b1; fixed_resp = lit_r; csd_low_seen = 1'b0;
        data_enc = lit_d; key_enc = lit_k; req_enc = 1'b1; t0 = cyc; dn = n_done;
        @(posedge clk); #1;
        req_enc = 1'b0; data_enc = ~lit_d; key_enc = '1;
        check("enc_ack_cycle", ack_cyc, t0);
        wait_done(dn, 900);
        check("enc_done_latency", done_cyc - t0, 793);
        check("enc_result", result, lit_r);
        check("enc_frame", cap_frame, {lit_d, lit_k});
        check("enc_cs_dec_idle", csd_low_seen, 0);
        fixed_resp_en = 1'b0;

        // Decrypt raised while busy
        csd_low_seen = 1'b0; csd_first_low = -1;
        data_enc = rnd128(); key_enc = rnd128(); req_enc = 1'b1; t0 = cyc; dn = n_done; an = n_ack;
        @(posedge clk); #1;
        req_enc = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        req_dec = 1'b1; data_dec = rnd128(); key_dec = rnd128();
        wait_done(dn, 900);
        d = done_cyc;
        @(posedge clk); #1;
        req_dec = 1'b0;
        check("dec_ack_after_done", ack_cyc, d + 1);
        check("dec_ack_is_dec", who_q[$], 1);
        dn = n_done;
        wait_done(dn, 900);
        check("dec_cs_first_low", csd_first_low, d + 2);
        check("dec_done_latency", done_cyc - (d + 1), 793);
        check("busy_ack_count", n_ack - an, 2);

        // Tie after reset: enc, dec, enc, dec back to back
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ack_q.delete(); done_q.delete(); who_q.delete();
        data_enc = rnd128(); key_enc = rnd128(); data_dec = rnd128(); key_dec = rnd128();
        req_enc = 1'b1; req_dec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dn = n_done;
            wait_done(dn, 900);
        end
        req_enc = 1'b0; req_dec = 1'b0;
        check("tie_grant_count", who_q.size(), 4);
        if (who_q.size() >= 4 && done_q.size() >= 3) begin
            for (int i = 0; i < 4; i++) check("tie_grant_order", who_q[i], i % 2);
            for (int i = 0; i < 3; i++) check("tie_regrant_cycle", ack_q[i+1], done_q[i] + 1);
        end

        // Reset during SEND
        @(posedge clk); #1;
        dn = n_done; data_enc = rnd128(); req_enc = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        req_enc = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_async", {busy, sclk, mosi, cs_enc_n, cs_dec_n, done_enc}, 6'b000_110);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (900) @(posedge clk);
        #1;
        check("rst_no_done", n_done, dn);
        data_enc = rnd128(); key_enc = rnd128(); req_enc = 1'b1; t0 = cyc; dn = n_done;
        @(posedge clk); #1;
        req_enc = 1'b0;
        wait_done(dn, 900);
        check("rst_next_latency", done_cyc - t0, 793);

        // Random request patterns, held levels and per-cycle operand churn
        for (int it = 0; it < 6; it++) begin
            sel  = $urandom_range(1, 3);
            hold = $urandom_range(1, 1700);
            for (int c = 0; c < hold; c++) begin
                req_enc = sel[0]; req_dec = sel[1];
                data_enc = rnd128(); key_enc = rnd128();
                data_dec = rnd128(); key_dec = rnd128();
                @(posedge clk); #1;
            end
            req_enc = 1'b0; req_dec = 1'b0;
            wait_idle(2000);
        end

        // Variant: DIV=3, Nk=8, LAT=14
        b_data = rnd128(); b_key = {rnd128(), rnd128()}; b_resp = rnd128();
        b_req = 1'b1; t0 = cyc; dn = b_n_done;
        @(posedge clk); #1;
        b_req = 1'b0; b_data = ~b_data;
        check("b_ack_cycle", b_ack_cyc, t0);
        for (int i = 0; i < 3300; i++) begin
            @(posedge clk); #1;
            if (b_n_done != dn) break;
        end
        check("b_done_seen", b_n_done - dn, 1);
        check("b_done_latency", b_done_cyc - t0, 3157);
        check("b_result", b_result, b_resp);
        check("b_frame", b_cap, {~b_data, b_key});
        check("b_rise_count", b_rises_at_done, 526);
        check("b_bad_phase_runs", b_bad, 0);
        check("b_sclk_transitions", b_trans, 1051);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
